// File: rtl/transmit_dac_pkg.sv
// Shared definitions for the DAC serial transmitter: FSM encoding, frame width
// and the DAC power-down mode codes.
package transmit_dac_pkg;

    localparam int FRAME_W = 16;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2
    } tx_state_t;

    // Half-period counter width; a divide-by-1 still needs one bit.
    function automatic int div_cnt_w(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/dac_sclk_div.sv
// Half-period counter for sclk: ticks once every CLK_DIV enabled cycles, with a
// one-cycle look-ahead tick used to register the end-of-frame pulse.
module dac_sclk_div
    import transmit_dac_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int CNT_W = div_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick     = i_en && (r_cnt == LAST);
    // With CLK_DIV=1 every enabled cycle is a tick, so there is no look-ahead.
    assign o_pre_tick = (CLK_DIV > 1) && i_en && (r_cnt == PRE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/transmit_dac.sv
// SPI-style transmitter for a 12-bit DAC: frames {2'b00, pd, din}, shifts it
// MSB-first with self-generated sclk and active-low sync.
//
//   state    | meaning
//   ST_IDLE  | cs=1, sclk=1, waiting for tx_start
//   ST_SHIFT | cs=0, sclk toggling, one bit per sclk period
//   ST_STOP  | cs=1, sclk=1 for CLK_DIV cycles of DAC quiet time
module transmit_dac
    import transmit_dac_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_tx_start,
    input  logic [DATA_W-1:0] i_din,
    input  logic [1:0]        i_pd,
    output logic              o_sclk,
    output logic              o_cs,
    output logic              o_sdata,
    output logic              o_tx_busy,
    output logic              o_tx_done_tick
);

    localparam int FRAME_LEN = DATA_W + 4;
    localparam int BIT_W     = $clog2(FRAME_LEN);

    tx_state_t            r_state, w_next_state;
    logic [FRAME_LEN-1:0] r_shift, w_next_shift;
    logic [BIT_W-1:0]     r_bit_cnt, w_next_bit_cnt;
    logic                 r_sclk, w_next_sclk;
    logic                 r_cs, w_next_cs;
    logic                 r_sdata, w_next_sdata;
    logic                 r_busy, r_done, w_next_done;
    logic                 w_accept, w_div_en, w_tick, w_pre_tick;
    logic [FRAME_LEN-1:0] w_frame;

    assign w_frame  = {2'b00, i_pd, i_din};
    assign w_div_en = (r_state != ST_IDLE);

    dac_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_div_en),
        .i_clr      (w_accept),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b1;
            r_cs      <= 1'b1;
            r_sdata   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_bit_cnt <= w_next_bit_cnt;
            r_sclk    <= w_next_sclk;
            r_cs      <= w_next_cs;
            r_sdata   <= w_next_sdata;
            r_busy    <= (w_next_state != ST_IDLE);
            r_done    <= w_next_done;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_shift   = r_shift;
        w_next_bit_cnt = r_bit_cnt;
        w_next_sclk    = r_sclk;
        w_next_cs      = r_cs;
        w_next_sdata   = r_sdata;
        w_next_done    = 1'b0;
        w_accept       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_cs   = 1'b1;
                w_next_sclk = 1'b1;
                if (i_tx_start) begin
                    w_accept       = 1'b1;
                    w_next_shift   = w_frame;
                    w_next_bit_cnt = BIT_W'(FRAME_LEN - 1);
                    w_next_cs      = 1'b0;
                    w_next_sdata   = w_frame[FRAME_LEN-1];
                    w_next_state   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (r_sclk) begin
                        // Falling edge: data held so the DAC samples a stable bit.
                        w_next_sclk = 1'b0;
                    end else if (r_bit_cnt != '0) begin
                        w_next_sclk    = 1'b1;
                        w_next_shift   = r_shift << 1;
                        w_next_sdata   = r_shift[FRAME_LEN-2];
                        w_next_bit_cnt = r_bit_cnt - 1'b1;
                    end else begin
                        w_next_sclk  = 1'b1;
                        w_next_cs    = 1'b1;
                        w_next_state = ST_STOP;
                        // A divide-by-1 stop phase is a single cycle, so it is also the last one.
                        w_next_done  = (CLK_DIV == 1);
                    end
                end
            end
            ST_STOP: begin
                w_next_cs   = 1'b1;
                w_next_sclk = 1'b1;
                w_next_done = w_pre_tick;
                if (w_tick) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cs    = 1'b1;
                w_next_sclk  = 1'b1;
            end
        endcase
    end

    assign o_sclk         = r_sclk;
    assign o_cs           = r_cs;
    assign o_sdata        = r_sdata;
    assign o_tx_busy      = r_busy;
    assign o_tx_done_tick = r_done;

endmodule
